// File: rtl/window_3x3_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers feed a 3x3 register
// array; out_valid/frame_done are registered one cycle after the completing pixel.
// Optional macro WINDOW_STRIDE2_EN restricts emitted windows to stride 2.
module window_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in,
  output logic                    out_valid,
  output logic [9*DATA_WIDTH-1:0] window,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] TWO_C    = CW'(2);
  localparam logic [RW-1:0] TWO_R    = RW'(2);

`ifdef WINDOW_STRIDE2_EN
  // Last emitted window sits on the largest row/col with an even offset from 2.
  localparam logic [CW-1:0] LAST_WIN_COL = CW'(2 + 2 * ((IMG_WIDTH - 3) / 2));
  localparam logic [RW-1:0] LAST_WIN_ROW = RW'(2 + 2 * ((IMG_HEIGHT - 3) / 2));
`else
  localparam logic [CW-1:0] LAST_WIN_COL = LAST_COL;
  localparam logic [RW-1:0] LAST_WIN_ROW = LAST_ROW;
`endif

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [3][3];

  logic accept;
  logic col_last;
  logic row_last;
  logic win_hit;
  logic done_hit;

  always_comb begin
    accept   = enable & in_valid;
    col_last = (col == LAST_COL);
    row_last = (row == LAST_ROW);
    win_hit  = (row >= TWO_R) && (col >= TWO_C);
`ifdef WINDOW_STRIDE2_EN
    // (row-2) and (col-2) even is the same as row and col even.
    win_hit  = win_hit && !row[0] && !col[0];
`endif
    done_hit = win_hit && (row == LAST_WIN_ROW) && (col == LAST_WIN_COL);
  end

  // Position counters and output strobes.
  always_ff @(posedge clk) begin
    if (resetn) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (enable) begin
      if (in_valid) begin
        out_valid  <= win_hit;
        frame_done <= done_hit;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        out_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  // Line buffers are shift chains; the tail of each is the pixel one row older.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      lb0[0] <= in;
      lb1[0] <= lb0[IMG_WIDTH-1];
      for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
        lb0[i] <= lb0[i-1];
        lb1[i] <= lb1[i-1];
      end
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[IMG_WIDTH-1];
      win[1][2] <= lb0[IMG_WIDTH-1];
      win[2][2] <= in;
    end
  end

  always_comb begin
    window = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      window[k*DATA_WIDTH +: DATA_WIDTH] = win[k/3][k%3];
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised and directed bench for window_3x3_gen on a 5x5 frame, checked
// against a frame-array reference model.
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;

`ifdef WINDOW_STRIDE2_EN
  localparam int EXP_WINDOWS = ((W - 1) / 2) * ((H - 1) / 2);
  localparam int LVR = 2 + 2 * ((H - 3) / 2);
  localparam int LVC = 2 + 2 * ((W - 3) / 2);
`else
  localparam int EXP_WINDOWS = (W - 2) * (H - 2);
  localparam int LVR = H - 1;
  localparam int LVC = W - 1;
`endif

  logic            clk;
  logic            resetn;
  logic            enable;
  logic            in_valid;
  logic [DW-1:0]   in;
  logic            out_valid;
  logic [9*DW-1:0] window;
  logic            frame_done;

  int checks;
  int failures;

  // reference model state
  logic [DW-1:0]   pix [H][W];
  int              m_row;
  int              m_col;
  logic            exp_valid;
  logic            exp_done;
  logic [9*DW-1:0] exp_win;

  window_3x3_gen #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .window    (window),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9*DW-1:0] win_of(input int tl);
    logic [9*DW-1:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*DW +: DW] = DW'(tl + r * W + c);
    return v;
  endfunction

  // Applies one cycle of inputs and advances the model; sampling is 1 time unit after the edge.
  task automatic step(input logic en, input logic v, input logic [DW-1:0] d, input logic rst);
    enable = en; in_valid = v; in = d; resetn = rst;
    if (rst) begin
      m_row = 0; m_col = 0; exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0;
    end else if (en) begin
      if (v) begin
        pix[m_row][m_col] = d;
        exp_valid = (m_row >= 2) && (m_col >= 2);
`ifdef WINDOW_STRIDE2_EN
        exp_valid = exp_valid && ((m_row - 2) % 2 == 0) && ((m_col - 2) % 2 == 0);
`endif
        exp_done = exp_valid && (m_row == LVR) && (m_col == LVC);
        if (exp_valid)
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              exp_win[(r*3+c)*DW +: DW] = pix[m_row-2+r][m_col-2+c];
        m_col = m_col + 1;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
      end else begin
        exp_valid = 1'b0; exp_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%b done=%b exp 0/0", out_valid, frame_done);
    end
    checks++;
    if (window !== '0) begin
      failures++;
      $display("FAIL reset_window got=%h exp=0", window);
    end
  endtask

  task automatic test_basic_frame();
    int n = 0;
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, 1'b1, DW'(p), 1'b0);
      checks++;
      if (out_valid !== exp_valid || frame_done !== exp_done) begin
        failures++;
        $display("FAIL basic_flags p=%0d got v=%b d=%b exp v=%b d=%b", p, out_valid, frame_done, exp_valid, exp_done);
      end
      if (exp_valid) begin
        checks++;
        if (window !== exp_win) begin
          failures++;
          $display("FAIL basic_window p=%0d got=%h exp=%h", p, window, exp_win);
        end
      end
      if (out_valid === 1'b1) begin
        n++;
        if (n == 1) begin
          checks++;
          if (p != 12 || window !== win_of(0)) begin
            failures++;
            $display("FAIL basic_first p=%0d got=%h exp p=12 win=%h", p, window, win_of(0));
          end
        end
      end
    end
    checks++;
    if (window !== win_of(12) || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_last got=%h done=%b exp=%h done=1", window, frame_done, win_of(12));
    end
    checks++;
    if (n != EXP_WINDOWS) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=%0d", n, EXP_WINDOWS);
    end
    step(1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || window !== win_of(12)) begin
      failures++;
      $display("FAIL basic_idle got v=%b d=%b win=%h exp v=0 d=0 win=%h", out_valid, frame_done, window, win_of(12));
    end
  endtask

  task automatic test_toggle_valid();
    int n = 0;
    logic prev = 1'b0;
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, 1'b1, DW'(p), 1'b0);
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (out_valid !== exp_valid || frame_done !== exp_done || (exp_valid && window !== exp_win)) begin
          failures++;
          $display("FAIL toggle p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h", p, out_valid, frame_done, window, exp_valid, exp_done, exp_win);
        end
        checks++;
        if (prev === 1'b1 && out_valid === 1'b1) begin
          failures++;
          $display("FAIL toggle_consecutive p=%0d got out_valid=1 exp 0", p);
        end
        if (out_valid === 1'b1) n++;
        prev = out_valid;
        if (s == 0) step(1'b1, 1'b0, DW'(8'hEE), 1'b0);
      end
    end
    checks++;
    if (n != EXP_WINDOWS) begin
      failures++;
      $display("FAIL toggle_count got=%0d exp=%0d", n, EXP_WINDOWS);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, 1'b1, DW'(p), 1'b0);
      checks++;
      if (out_valid !== exp_valid || frame_done !== exp_done || (exp_valid && window !== exp_win)) begin
        failures++;
        $display("FAIL stall_stream p=%0d got v=%b w=%h exp v=%b w=%h", p, out_valid, window, exp_valid, exp_win);
      end
      if (out_valid === 1'b1) n++;
      if (p == 12) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 1'b1, DW'(8'hAA), 1'b0);
          checks++;
          if (out_valid !== 1'b1 || frame_done !== 1'b0 || window !== win_of(0)) begin
            failures++;
            $display("FAIL stall_hold s=%0d got v=%b d=%b w=%h exp v=1 d=0 w=%h", s, out_valid, frame_done, window, win_of(0));
          end
        end
      end
    end
    checks++;
    if (n != EXP_WINDOWS) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=%0d", n, EXP_WINDOWS);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    for (int p = 0; p < 9; p++) step(1'b1, 1'b1, DW'(8'h40 + p), 1'b0);
    step(1'b1, 1'b1, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || window !== '0) begin
      failures++;
      $display("FAIL midreset_clear got v=%b w=%h exp v=0 w=0", out_valid, window);
    end
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, 1'b1, DW'(p), 1'b0);
      checks++;
      if (out_valid !== exp_valid || frame_done !== exp_done || (exp_valid && window !== exp_win)) begin
        failures++;
        $display("FAIL midreset_stream p=%0d got v=%b w=%h exp v=%b w=%h", p, out_valid, window, exp_valid, exp_win);
      end
      if (out_valid === 1'b1) begin
        n++;
        if (n == 1) begin
          checks++;
          if (p != 12 || window !== win_of(0)) begin
            failures++;
            $display("FAIL midreset_first p=%0d got=%h exp p=12 win=%h", p, window, win_of(0));
          end
        end
      end
    end
    checks++;
    if (n != EXP_WINDOWS) begin
      failures++;
      $display("FAIL midreset_count got=%0d exp=%0d", n, EXP_WINDOWS);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int n2 = 0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < W * H; p++) begin
        step(1'b1, 1'b1, DW'(f * 100 + p), 1'b0);
        checks++;
        if (out_valid !== exp_valid || frame_done !== exp_done || (exp_valid && window !== exp_win)) begin
          failures++;
          $display("FAIL b2b f=%0d p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h", f, p, out_valid, frame_done, window, exp_valid, exp_done, exp_win);
        end
        if (frame_done === 1'b1) dones++;
        if (f == 1 && out_valid === 1'b1) begin
          n2++;
          if (n2 == 1) begin
            checks++;
            if (window !== win_of(100)) begin
              failures++;
              $display("FAIL b2b_first2 got=%h exp=%h", window, win_of(100));
            end
          end
        end
      end
    end
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=2", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, DW'($urandom), ($urandom % 150) == 0);
      checks++;
      if (out_valid !== exp_valid || frame_done !== exp_done || (exp_valid && window !== exp_win)) begin
        failures++;
        $display("FAIL random i=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h", i, out_valid, frame_done, window, exp_valid, exp_done, exp_win);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b1; enable = 1'b0; in_valid = 1'b0; in = '0;
    m_row = 0; m_col = 0; exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0;
    test_reset();
    test_basic_frame();
    test_toggle_valid();
    test_stall();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 sliding-window generator for the CNN datapath.
- Accepts one raster-order pixel per cycle; produces a full 3x3 neighbourhood each time a complete window exists.
- Window is registered, with a valid strobe and an end-of-frame pulse.
- Sits directly upstream of the convolution stage. That stage's control/data alignment delay chains count the one-cycle latency defined here.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- IMG_WIDTH, 32, pixels per row; legal range 3 to 1024.
- IMG_HEIGHT, 32, rows per frame; legal range 3 to 1024.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active-high: reset takes effect on a clk edge while resetn=1.
- enable  input  1  global stall; 0 freezes all state and outputs.
- in_valid  input  1  pixel on in is presented this cycle.
- in  input  DATA_WIDTH  pixel, raster order (row-major, left to right).
- out_valid  output  1  window holds a valid 3x3 neighbourhood.
- window  output  9*DATA_WIDTH  element k=r*3+c at bits [k*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row, c=0 the leftmost column.
- frame_done  output  1  single-cycle pulse coincident with the last out_valid of a frame.

Behaviour:
Storage:
- Two line buffers, each IMG_WIDTH deep. Each is a shift chain or a RAM with a shared write pointer.
- A 3x3 register array; each accepted pixel shifts the array left.
- New column = {line buffer 1 output, line buffer 0 output, in}.

Counters:
- col counts 0..IMG_WIDTH-1; row counts 0..IMG_HEIGHT-1.
- Both advance only on an accepted pixel (enable=1 and in_valid=1).
- col wraps to 0 and increments row. At col=IMG_WIDTH-1 and row=IMG_HEIGHT-1, both wrap to 0 and the next frame starts immediately.

Output rules:
- The window is valid when the accepted pixel has row>=2 and col>=2 (no padding, stride 1).
- Latency: out_valid=1 on the cycle after that pixel is accepted, with window already updated.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Pixels at col 0 and 1 still shift through the array and line buffers, but do not raise out_valid. Windows never straddle rows.
- frame_done=1 together with out_valid for the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.

Stall and idle:
- enable=1, in_valid=0: counters and buffers hold; out_valid and frame_done go to 0 next cycle; window holds its last value.
- enable=0: every register, including out_valid, window and frame_done, holds. A pending out_valid=1 stays asserted until enable returns.

Reset:
- Reset dominates enable.
- After reset: col=0, row=0, out_valid=0, frame_done=0, window=0, line buffer contents=0.
- Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).

Width: no arithmetic on pixel data; counters are sized as clog2 of the respective dimension.

Optional Feature:
- Macro: WINDOW_STRIDE2_EN.
- Defined: out_valid (and frame_done eligibility) additionally requires (row-2) and (col-2) both even, giving stride-2 windows. Windows per frame become ceil((IMG_WIDTH-2)/2)*ceil((IMG_HEIGHT-2)/2). frame_done pulses on the last emitted window, which may precede the frame's final pixel. Counters and buffers behave exactly as in the default.
- Undefined: stride 1 as above.

Test Plan:
- Basic frame, IMG_WIDTH=5, IMG_HEIGHT=5, pixels 0..24 back-to-back: first out_valid one cycle after pixel 12 with window {0,1,2,5,6,7,10,11,12}. Exactly 9 valid cycles. Last window is {12,13,14,17,18,19,22,23,24} with frame_done=1.
- Same frame with in_valid toggled 1,0,1,0: identical 9 windows in order; out_valid never on consecutive cycles; no data loss.
- enable=0 for 3 cycles right after out_valid rises on window {0,1,2,5,6,7,10,11,12}: out_valid stays 1 and window holds for 3 cycles; resumes correctly.
- Reset asserted after pixel 8, then a fresh 0..24 frame: no out_valid before the new pixel 12; outputs match the basic frame.
- Two frames back-to-back (0..24, then 100..124): second frame's first window is {100,101,102,105,106,107,110,111,112}; frame_done pulses exactly twice.
- With WINDOW_STRIDE2_EN on a 5x5 frame: 4 windows, top-left pixels 0, 2, 10, 12; frame_done on the window with top-left 12.
